// File: rtl/timed_pulse_pkg.sv
// Shared types and constants for the timed pulse generator.
package timed_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    PULSE,
    HOLD
  } tpg_state_t;

  localparam int CNT_W_DEF = 3;
  localparam int CNT_MAX   = (1 << CNT_W_DEF) - 1;

endpackage

// File: rtl/load_down_counter.sv
// Loadable down-counter that saturates at zero; shared by all timed states.
module load_down_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - ONE;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/timed_pulse_gen.sv
// Programmable timed-pulse generator: delay, pulse of programmed width,
// one-cycle done strobe, then an optional hold-off before new work.
module timed_pulse_gen
  import timed_pulse_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int HOLDOFF = 1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] width,
  output logic             pulse,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = (HOLDOFF > 0) ? CNT_W'(HOLDOFF - 1) : '0;

  tpg_state_t       state, state_n;
  logic [CNT_W-1:0] width_q, width_n;
  logic             pulse_n, busy_n, done_n;
  logic             finish;
  logic             cnt_load, cnt_en, cnt_zero;
  logic [CNT_W-1:0] cnt_load_value;
  logic [CNT_W-1:0] cnt_count;

  load_down_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clock     (clock),
    .clear     (clear),
    .load      (cnt_load),
    .load_value(cnt_load_value),
    .en        (cnt_en),
    .count     (cnt_count),
    .zero      (cnt_zero)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state   <= IDLE;
      width_q <= '0;
      pulse   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      width_q <= width_n;
      pulse   <= pulse_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  // Outputs are computed one edge ahead so every output leaves a flop.
  always_comb begin
    state_n        = state;
    width_n        = width_q;
    pulse_n        = pulse;
    busy_n         = busy;
    done_n         = 1'b0;
    finish         = 1'b0;
    cnt_load       = 1'b0;
    cnt_load_value = '0;
    cnt_en         = 1'b0;

    if (abort && (state != IDLE)) begin
      state_n = IDLE;
      pulse_n = 1'b0;
      busy_n  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            width_n = width;
            busy_n  = 1'b1;
            if (delay != '0) begin
              state_n        = DELAY;
              cnt_load       = 1'b1;
              cnt_load_value = delay - ONE;
            end else if (width != '0) begin
              state_n        = PULSE;
              pulse_n        = 1'b1;
              cnt_load       = 1'b1;
              cnt_load_value = width - ONE;
            end else begin
              finish = 1'b1;
            end
          end
        end
        DELAY: begin
          if (!cnt_zero) begin
            cnt_en = 1'b1;
          end else if (width_q != '0) begin
            state_n        = PULSE;
            pulse_n        = 1'b1;
            cnt_load       = 1'b1;
            cnt_load_value = width_q - ONE;
          end else begin
            finish = 1'b1;
          end
        end
        PULSE: begin
          if (!cnt_zero) begin
            cnt_en = 1'b1;
          end else begin
            finish = 1'b1;
          end
        end
        HOLD: begin
          if (!cnt_zero) begin
            cnt_en = 1'b1;
          end else begin
            state_n = IDLE;
            busy_n  = 1'b0;
          end
        end
        default: begin
          state_n = IDLE;
          pulse_n = 1'b0;
          busy_n  = 1'b0;
        end
      endcase

      // Shared completion path: done strobe, then hold-off or straight to IDLE.
      if (finish) begin
        done_n  = 1'b1;
        pulse_n = 1'b0;
        if (HOLDOFF > 0) begin
          state_n        = HOLD;
          busy_n         = 1'b1;
          cnt_load       = 1'b1;
          cnt_load_value = HOLD_LOAD;
        end else begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_timed_pulse_gen.sv
// Bench for timed_pulse_gen: HOLDOFF=1 and HOLDOFF=0 instances share stimulus
// and are compared every cycle against a run-timeline reference model.
module tb_timed_pulse_gen;

  logic       clock;
  logic       clear;
  logic       start;
  logic       abort;
  logic [2:0] delay;
  logic [2:0] width;
  logic       pulse0, busy0, done0;
  logic       pulse1, busy1, done1;

  int passed = 0;
  int total  = 0;

  // Reference model: one run per instance, described by acceptance edge s,
  // operands d/w and the edge e at which the block is back in IDLE.
  int n = 0;
  int act  [2];
  int s    [2];
  int d    [2];
  int w    [2];
  int e    [2];
  int hold [2];

  timed_pulse_gen #(.CNT_W(3), .HOLDOFF(1)) u_dut0 (
    .clock(clock), .clear(clear), .start(start), .abort(abort),
    .delay(delay), .width(width),
    .pulse(pulse0), .busy(busy0), .done(done0)
  );

  timed_pulse_gen #(.CNT_W(3), .HOLDOFF(0)) u_dut1 (
    .clock(clock), .clear(clear), .start(start), .abort(abort),
    .delay(delay), .width(width),
    .pulse(pulse1), .busy(busy1), .done(done1)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s edge=%0d observed=%b expected=%b", tag, n, obs, exp);
  endtask

  task automatic model_edge();
    n++;
    for (int i = 0; i < 2; i++) begin
      if (act[i] != 0 && n > s[i] && n <= e[i]) begin
        if (abort) act[i] = 0;
      end else begin
        act[i] = 0;
        if (start && !abort) begin
          act[i] = 1;
          s[i]   = n;
          d[i]   = int'(delay);
          w[i]   = int'(width);
          e[i]   = n + d[i] + w[i] + hold[i];
        end
      end
    end
  endtask

  task automatic check_all();
    logic ep, eb, ed;
    logic [2:0] obs [2];
    obs[0] = {pulse0, busy0, done0};
    obs[1] = {pulse1, busy1, done1};
    for (int i = 0; i < 2; i++) begin
      ep = (act[i] != 0) && (w[i] > 0) && (n >= s[i] + d[i]) && (n < s[i] + d[i] + w[i]);
      eb = (act[i] != 0) && (n < e[i]);
      ed = (act[i] != 0) && (n == s[i] + d[i] + w[i]);
      chk($sformatf("pulse_h%0d", hold[i]), obs[i][2], ep);
      chk($sformatf("busy_h%0d",  hold[i]), obs[i][1], eb);
      chk($sformatf("done_h%0d",  hold[i]), obs[i][0], ed);
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  // Clear pulsed between edges: outputs must drop with no clock edge.
  task automatic do_clear();
    #2;
    clear = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) act[i] = 0;
    chk("clr_pulse_h1", pulse0, 1'b0);
    chk("clr_busy_h1",  busy0,  1'b0);
    chk("clr_done_h1",  done0,  1'b0);
    chk("clr_pulse_h0", pulse1, 1'b0);
    chk("clr_busy_h0",  busy1,  1'b0);
    chk("clr_done_h0",  done1,  1'b0);
    #1;
    clear = 1'b0;
  endtask

  initial begin
    hold[0] = 1;
    hold[1] = 0;
    for (int i = 0; i < 2; i++) begin
      act[i] = 0; s[i] = 0; d[i] = 0; w[i] = 0; e[i] = 0;
    end
    clock = 1'b0;
    clear = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    delay = '0;
    width = '0;
    #1;
    check_all();
    repeat (2) @(posedge clock);
    #1;
    clear = 1'b0;
    step();

    // Nominal D=3 W=4, with start pulses during DELAY and during HOLD
    delay = 3'd3; width = 3'd4; start = 1'b1; step();
    start = 1'b0; delay = 3'd7; width = 3'd7; step();
    start = 1'b1; step();
    start = 1'b0; repeat (5) step();
    start = 1'b1; delay = 3'd1; width = 3'd1; step();
    start = 1'b0; repeat (10) step();

    // Zero operands
    delay = 3'd0; width = 3'd1; start = 1'b1; step();
    start = 1'b0; repeat (4) step();
    delay = 3'd0; width = 3'd0; start = 1'b1; step();
    start = 1'b0; repeat (4) step();

    // Back-to-back with start held
    delay = 3'd0; width = 3'd2; start = 1'b1; repeat (10) step();
    start = 1'b0; repeat (5) step();

    // Abort on the second high cycle of W=5
    delay = 3'd1; width = 3'd5; start = 1'b1; step();
    start = 1'b0; step(); step();
    abort = 1'b1; step();
    abort = 1'b0; repeat (3) step();

    // Abort beats start in IDLE
    abort = 1'b1; start = 1'b1; delay = 3'd0; width = 3'd3; step();
    abort = 1'b0; start = 1'b0; repeat (3) step();

    // Clear mid-pulse
    delay = 3'd3; width = 3'd4; start = 1'b1; step();
    start = 1'b0; repeat (4) step();
    do_clear();
    repeat (3) step();

    // Randomized traffic
    repeat (600) begin
      start = ($urandom_range(0, 2) == 0);
      abort = ($urandom_range(0, 15) == 0);
      delay = 3'($urandom_range(0, 7));
      width = 3'($urandom_range(0, 7));
      step();
      if ($urandom_range(0, 99) == 0) do_clear();
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (12) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
